// File: rtl/byte_stream_unpacker_pkg.sv
// Shared types and default sizing for the byte stream unpacker.
package unpacker_pkg;

  // Width of a byte count that must be able to hold the value n itself.
  function automatic int count_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int DEF_IN_BYTES    = 8;
  localparam int DEF_OUT_BYTES   = 16;
  localparam int DEF_DEPTH_BYTES = 64;

  localparam int DEF_PTR_W     = $clog2(DEF_DEPTH_BYTES);
  localparam int DEF_IN_CNT_W  = count_w(DEF_IN_BYTES);
  localparam int DEF_OUT_CNT_W = count_w(DEF_OUT_BYTES);
  localparam int DEF_OCC_W     = count_w(DEF_DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/byte_stream_unpacker_if.sv
// Ingress word bus and egress byte window of the unpacker.
interface byte_stream_unpacker_if
  import unpacker_pkg::*;
#(
  parameter int IN_BYTES  = DEF_IN_BYTES,
  parameter int OUT_BYTES = DEF_OUT_BYTES
);
  localparam int IN_CNT_W  = count_w(IN_BYTES);
  localparam int OUT_CNT_W = count_w(OUT_BYTES);

  logic [IN_BYTES-1:0][7:0]  dataIn;
  logic                      dataInValid;
  logic                      dataInReady;
  logic                      dataInLast;
  logic [IN_CNT_W-1:0]       dataInLastBytes;
  logic [OUT_BYTES-1:0][7:0] dataOut;
  logic [OUT_CNT_W-1:0]      dataOutBytesValid;
  logic [OUT_CNT_W-1:0]      dataOutConsume;
  logic                      streamDone;
  logic                      consumeError;

  // Upstream producer plus downstream consumer side.
  modport master (
    output dataIn, dataInValid, dataInLast, dataInLastBytes, dataOutConsume,
    input  dataInReady, dataOut, dataOutBytesValid, streamDone, consumeError
  );

  // The unpacker itself.
  modport slave (
    input  dataIn, dataInValid, dataInLast, dataInLastBytes, dataOutConsume,
    output dataInReady, dataOut, dataOutBytesValid, streamDone, consumeError
  );

endinterface

// File: rtl/byte_stream_unpacker_ring.sv
// Circular byte store: multi-byte write at wrPtr, sliding read window at rdPtr.
// The caller guarantees writes never overrun unread bytes.
module byte_ring_buffer
  import unpacker_pkg::*;
#(
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int IN_BYTES    = DEF_IN_BYTES,
  parameter int OUT_BYTES   = DEF_OUT_BYTES
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wr_en_i,
  input  logic [IN_BYTES-1:0][7:0]             wr_data_i,
  input  logic [count_w(IN_BYTES)-1:0]         wr_cnt_i,
  input  logic [count_w(OUT_BYTES)-1:0]        rd_adv_i,
  output logic [OUT_BYTES-1:0][7:0]            win_o
);
  localparam int PW  = $clog2(DEPTH_BYTES);
  localparam int ICW = count_w(IN_BYTES);

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_idx [IN_BYTES];
  logic [IN_BYTES-1:0] wr_lane;

  // Pointer advance; wrap is the natural overflow of the PW-bit pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_en_i ? PW'(wr_cnt_i) : '0);
    rd_ptr_d = rd_ptr_q + PW'(rd_adv_i);
  end

  // Per-lane destination address and enable for the lowest wr_cnt_i bytes.
  always_comb begin
    for (int i = 0; i < IN_BYTES; i++) begin
      wr_idx[i]  = wr_ptr_q + PW'(i);
      wr_lane[i] = wr_en_i && (ICW'(i) < wr_cnt_i);
    end
  end

  // Pointer registers, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Byte storage; contents need no reset because only written bytes are exposed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_BYTES; i++) begin
      if (wr_lane[i]) begin
        mem_q[wr_idx[i]] <= wr_data_i[i];
      end
    end
  end

  // Read window starting at rdPtr, wrapping around the ring.
  always_comb begin
    for (int k = 0; k < OUT_BYTES; k++) begin
      win_o[k] = mem_q[rd_ptr_q + PW'(k)];
    end
  end

endmodule

// File: rtl/byte_stream_unpacker.sv
// Byte-granular reader for the packed return path: buffers fixed-width input
// words and exposes a sliding window that the decompressor consumes from.
// FIFO_DEPTH_BYTES must be a power of 2 and at least 2*NUM_BYTES_OUTPUT_WIDTH.
module byte_stream_unpacker
  import unpacker_pkg::*;
#(
  parameter int NUM_BYTES_INPUT_WIDTH  = DEF_IN_BYTES,
  parameter int NUM_BYTES_OUTPUT_WIDTH = DEF_OUT_BYTES,
  parameter int FIFO_DEPTH_BYTES       = DEF_DEPTH_BYTES
) (
  input logic                   clk,
  input logic                   reset,
  byte_stream_unpacker_if.slave bus
);
  localparam int ICW = count_w(NUM_BYTES_INPUT_WIDTH);
  localparam int OCW = count_w(NUM_BYTES_OUTPUT_WIDTH);
  localparam int QW  = count_w(FIFO_DEPTH_BYTES);

  // Highest occupancy at which a full input word still fits.
  localparam logic [QW-1:0] READY_LIMIT = QW'(FIFO_DEPTH_BYTES - NUM_BYTES_INPUT_WIDTH);
  localparam logic [QW-1:0] WIN_BYTES_Q = QW'(NUM_BYTES_OUTPUT_WIDTH);

  // Visible window size: occupancy saturated at the window width.
  function automatic logic [OCW-1:0] window_count(input logic [QW-1:0] occ);
    if (occ > WIN_BYTES_Q) begin
      return OCW'(NUM_BYTES_OUTPUT_WIDTH);
    end
    return OCW'(occ);
  endfunction

  // Consume request clamped to what the window actually holds.
  function automatic logic [OCW-1:0] clamp_consume(input logic [OCW-1:0] req,
                                                   input logic [OCW-1:0] avail);
    return (req > avail) ? avail : req;
  endfunction

  state_t                  state_q, state_d;
  logic [QW-1:0]           occ_q, occ_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic [ICW-1:0]          wr_bytes;
  logic [OCW-1:0]          win_cnt;
  logic [OCW-1:0]          eff_consume;
  logic                    over_consume;
  logic [NUM_BYTES_OUTPUT_WIDTH-1:0][7:0] win_raw;

  // Write size, consume clamp and next occupancy.
  always_comb begin
    accept       = bus.dataInValid && ready_q;
    wr_bytes     = (bus.dataInLast && (bus.dataInLastBytes != '0)) ?
                   bus.dataInLastBytes : ICW'(NUM_BYTES_INPUT_WIDTH);
    win_cnt      = window_count(occ_q);
    eff_consume  = clamp_consume(bus.dataOutConsume, win_cnt);
    over_consume = (bus.dataOutConsume > win_cnt);
    occ_d        = occ_q + (accept ? QW'(wr_bytes) : '0) - QW'(eff_consume);
  end

  // Stream framing FSM; ready is precomputed from the next state so that it
  // is a clean register output with no path from dataInValid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = bus.dataInLast ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (accept && bus.dataInLast) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_d == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = ((state_d == IDLE) || (state_d == STREAM)) && (occ_d <= READY_LIMIT);
    err_d   = err_q || over_consume;
  end

  // Control state, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      occ_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  byte_ring_buffer #(
    .DEPTH_BYTES (FIFO_DEPTH_BYTES),
    .IN_BYTES    (NUM_BYTES_INPUT_WIDTH),
    .OUT_BYTES   (NUM_BYTES_OUTPUT_WIDTH)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (accept),
    .wr_data_i (bus.dataIn),
    .wr_cnt_i  (wr_bytes),
    .rd_adv_i  (eff_consume),
    .win_o     (win_raw)
  );

  // Zero bytes beyond the valid count so the window is never stale or X.
  always_comb begin
    bus.dataOut = '0;
    for (int k = 0; k < NUM_BYTES_OUTPUT_WIDTH; k++) begin
      if (OCW'(k) < win_cnt) begin
        bus.dataOut[k] = win_raw[k];
      end
    end
  end

  assign bus.dataInReady       = ready_q;
  assign bus.dataOutBytesValid = win_cnt;
  assign bus.streamDone        = (state_q == DONE);
  assign bus.consumeError      = err_q;

endmodule

// File: tb/tb_byte_stream_unpacker.sv
// Directed bench for byte_stream_unpacker.
module tb_byte_stream_unpacker;
  localparam int IN    = 8;
  localparam int OUT   = 16;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  byte_stream_unpacker_if #(.IN_BYTES(IN), .OUT_BYTES(OUT)) bus ();

  byte_stream_unpacker #(
    .NUM_BYTES_INPUT_WIDTH  (IN),
    .NUM_BYTES_OUTPUT_WIDTH (OUT),
    .FIFO_DEPTH_BYTES       (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.dataIn          = '0;
    bus.dataInValid     = 1'b0;
    bus.dataInLast      = 1'b0;
    bus.dataInLastBytes = '0;
    bus.dataOutConsume  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; unused bytes of a short word carry 0xEE.
  task automatic drive(input bit valid, input logic [7:0] first, input bit last,
                       input int lb, input int consume);
    int n;
    n = (last && lb != 0) ? lb : IN;
    for (int i = 0; i < IN; i++) bus.dataIn[i] = (i < n) ? first + 8'(i) : 8'hEE;
    bus.dataInValid     = valid;
    bus.dataInLast      = last;
    bus.dataInLastBytes = 4'(lb);
    bus.dataOutConsume  = 5'(consume);
    tick();
    idle_inputs();
  endtask

  function automatic logic [OUT-1:0][7:0] exp_win(input logic [7:0] first, input int n);
    logic [OUT-1:0][7:0] w;
    for (int k = 0; k < OUT; k++) w[k] = (k < n) ? first + 8'(k) : 8'h00;
    return w;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (bus.dataInReady !== 1'b0) $display("FAIL rst_ready got %0b exp 0", bus.dataInReady); else passes++;
    checks++; if (bus.dataOutBytesValid !== 5'd0) $display("FAIL rst_bv got %0d exp 0", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataOut !== '0) $display("FAIL rst_dout got %h exp 0", bus.dataOut); else passes++;
    checks++; if (bus.streamDone !== 1'b0) $display("FAIL rst_done got %0b exp 0", bus.streamDone); else passes++;
    checks++; if (bus.consumeError !== 1'b0) $display("FAIL rst_err got %0b exp 0", bus.consumeError); else passes++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (bus.dataInReady !== 1'b1) $display("FAIL rst_rel_ready got %0b exp 1", bus.dataInReady); else passes++;
  endtask

  task automatic test_single_word(input logic [7:0] first);
    drive(1'b1, first, 1'b1, 0, 0);
    checks++; if (bus.dataOutBytesValid !== 5'd8) $display("FAIL sw_bv got %0d exp 8", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataOut !== exp_win(first, 8)) $display("FAIL sw_dout got %h exp %h", bus.dataOut, exp_win(first, 8)); else passes++;
    checks++; if (bus.dataInReady !== 1'b0) $display("FAIL sw_drain_ready got %0b exp 0", bus.dataInReady); else passes++;
    checks++; if (bus.streamDone !== 1'b0) $display("FAIL sw_early_done got %0b exp 0", bus.streamDone); else passes++;
    drive(1'b0, 8'h00, 1'b0, 0, 8);
    checks++; if (bus.streamDone !== 1'b1) $display("FAIL sw_done got %0b exp 1", bus.streamDone); else passes++;
    checks++; if (bus.dataOutBytesValid !== 5'd0) $display("FAIL sw_bv_empty got %0d exp 0", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataOut !== '0) $display("FAIL sw_dout_empty got %h exp 0", bus.dataOut); else passes++;
    drive(1'b0, 8'h00, 1'b0, 0, 0);
    checks++; if (bus.streamDone !== 1'b0) $display("FAIL sw_done_pulse got %0b exp 0", bus.streamDone); else passes++;
    checks++; if (bus.dataInReady !== 1'b1) $display("FAIL sw_idle_ready got %0b exp 1", bus.dataInReady); else passes++;
    checks++; if (bus.consumeError !== 1'b0) $display("FAIL sw_err got %0b exp 0", bus.consumeError); else passes++;
  endtask

  task automatic test_fill_and_wrap();
    int wr_val, exp_rd, occ_m, c, exp_bv;
    bit v;
    for (int w = 0; w < 8; w++) begin
      checks++; if (bus.dataInReady !== 1'b1) $display("FAIL fill_ready_%0d got %0b exp 1", w, bus.dataInReady); else passes++;
      drive(1'b1, 8'(w * 8), 1'b0, 0, 0);
    end
    checks++; if (bus.dataInReady !== 1'b0) $display("FAIL fill_full_ready got %0b exp 0", bus.dataInReady); else passes++;
    checks++; if (bus.dataOutBytesValid !== 5'd16) $display("FAIL fill_bv got %0d exp 16", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataOut !== exp_win(8'h00, 16)) $display("FAIL fill_dout got %h exp %h", bus.dataOut, exp_win(8'h00, 16)); else passes++;

    // Consume 5 per cycle while refilling whenever ready.
    wr_val = 64; exp_rd = 0; occ_m = 64;
    for (int i = 0; i < 40; i++) begin
      v = bus.dataInReady;
      for (int b = 0; b < IN; b++) bus.dataIn[b] = 8'(wr_val + b);
      bus.dataInValid    = v;
      bus.dataOutConsume = 5'd5;
      tick();
      idle_inputs();
      if (v) begin wr_val += 8; occ_m += 8; end
      occ_m  -= 5;
      exp_rd += 5;
      exp_bv = (occ_m < 16) ? occ_m : 16;
      checks++; if (bus.dataOut[0] !== 8'(exp_rd)) $display("FAIL wrap_head_%0d got %h exp %h", i, bus.dataOut[0], 8'(exp_rd)); else passes++;
      checks++; if (bus.dataOutBytesValid !== 5'(exp_bv)) $display("FAIL wrap_bv_%0d got %0d exp %0d", i, bus.dataOutBytesValid, exp_bv); else passes++;
      checks++; if (bus.dataInReady !== (occ_m <= DEPTH - IN)) $display("FAIL wrap_ready_%0d got %0b exp %0b", i, bus.dataInReady, occ_m <= DEPTH - IN); else passes++;
    end

    // Drain without closing the stream.
    for (int j = 0; j < 8 && occ_m > 0; j++) begin
      c = (occ_m < 16) ? occ_m : 16;
      drive(1'b0, 8'h00, 1'b0, 0, c);
      occ_m  -= c;
      exp_rd += c;
      exp_bv = (occ_m < 16) ? occ_m : 16;
      checks++; if (bus.dataOutBytesValid !== 5'(exp_bv)) $display("FAIL drain_bv_%0d got %0d exp %0d", j, bus.dataOutBytesValid, exp_bv); else passes++;
      if (occ_m > 0) begin
        checks++; if (bus.dataOut[0] !== 8'(exp_rd)) $display("FAIL drain_head_%0d got %h exp %h", j, bus.dataOut[0], 8'(exp_rd)); else passes++;
      end
    end

    // Close the stream with a one-byte last word.
    drive(1'b1, 8'(wr_val), 1'b1, 1, 0);
    checks++; if (bus.dataOut !== exp_win(8'(wr_val), 1)) $display("FAIL close_dout got %h exp %h", bus.dataOut, exp_win(8'(wr_val), 1)); else passes++;
    checks++; if (bus.dataInReady !== 1'b0) $display("FAIL close_ready got %0b exp 0", bus.dataInReady); else passes++;
    drive(1'b0, 8'h00, 1'b0, 0, 1);
    checks++; if (bus.streamDone !== 1'b1) $display("FAIL close_done got %0b exp 1", bus.streamDone); else passes++;
    drive(1'b0, 8'h00, 1'b0, 0, 0);
    checks++; if (bus.streamDone !== 1'b0) $display("FAIL close_done_pulse got %0b exp 0", bus.streamDone); else passes++;
  endtask

  task automatic test_partial_last();
    drive(1'b1, 8'h10, 1'b0, 0, 0);
    drive(1'b1, 8'h18, 1'b0, 0, 0);
    drive(1'b1, 8'h20, 1'b1, 3, 0);
    checks++; if (bus.dataOutBytesValid !== 5'd16) $display("FAIL part_bv got %0d exp 16", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataOut !== exp_win(8'h10, 16)) $display("FAIL part_dout got %h exp %h", bus.dataOut, exp_win(8'h10, 16)); else passes++;
    checks++; if (bus.dataInReady !== 1'b0) $display("FAIL part_ready got %0b exp 0", bus.dataInReady); else passes++;
    drive(1'b0, 8'h00, 1'b0, 0, 16);
    checks++; if (bus.dataOutBytesValid !== 5'd3) $display("FAIL part_bv3 got %0d exp 3", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataOut !== exp_win(8'h20, 3)) $display("FAIL part_tail got %h exp %h", bus.dataOut, exp_win(8'h20, 3)); else passes++;
    checks++; if (bus.streamDone !== 1'b0) $display("FAIL part_early_done got %0b exp 0", bus.streamDone); else passes++;
    drive(1'b0, 8'h00, 1'b0, 0, 3);
    checks++; if (bus.streamDone !== 1'b1) $display("FAIL part_done got %0b exp 1", bus.streamDone); else passes++;
    checks++; if (bus.consumeError !== 1'b0) $display("FAIL part_err_clear got %0b exp 0", bus.consumeError); else passes++;
    drive(1'b0, 8'h00, 1'b0, 0, 1);
    checks++; if (bus.consumeError !== 1'b1) $display("FAIL part_err_set got %0b exp 1", bus.consumeError); else passes++;
    checks++; if (bus.streamDone !== 1'b0) $display("FAIL part_done_pulse got %0b exp 0", bus.streamDone); else passes++;
  endtask

  task automatic test_over_consume();
    rst_n = 1'b0;
    #2;
    checks++; if (bus.consumeError !== 1'b0) $display("FAIL oc_rst_err got %0b exp 0", bus.consumeError); else passes++;
    @(negedge clk) rst_n = 1'b1;
    tick();
    drive(1'b1, 8'hA0, 1'b1, 4, 0);
    checks++; if (bus.dataOutBytesValid !== 5'd4) $display("FAIL oc_bv got %0d exp 4", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataOut !== exp_win(8'hA0, 4)) $display("FAIL oc_dout got %h exp %h", bus.dataOut, exp_win(8'hA0, 4)); else passes++;
    drive(1'b0, 8'h00, 1'b0, 0, 10);
    checks++; if (bus.dataOutBytesValid !== 5'd0) $display("FAIL oc_bv0 got %0d exp 0", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.consumeError !== 1'b1) $display("FAIL oc_err got %0b exp 1", bus.consumeError); else passes++;
    checks++; if (bus.streamDone !== 1'b1) $display("FAIL oc_done got %0b exp 1", bus.streamDone); else passes++;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 0, 0);
    checks++; if (bus.consumeError !== 1'b1) $display("FAIL oc_err_sticky got %0b exp 1", bus.consumeError); else passes++;
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 8'h50, 1'b0, 0, 0);
    drive(1'b1, 8'h58, 1'b0, 0, 0);
    drive(1'b1, 8'h60, 1'b0, 0, 0);
    checks++; if (bus.dataOutBytesValid !== 5'd16) $display("FAIL mr_bv got %0d exp 16", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataOut !== exp_win(8'h50, 16)) $display("FAIL mr_dout got %h exp %h", bus.dataOut, exp_win(8'h50, 16)); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dataOutBytesValid !== 5'd0) $display("FAIL mr_rst_bv got %0d exp 0", bus.dataOutBytesValid); else passes++;
    checks++; if (bus.dataInReady !== 1'b0) $display("FAIL mr_rst_ready got %0b exp 0", bus.dataInReady); else passes++;
    checks++; if (bus.dataOut !== '0) $display("FAIL mr_rst_dout got %h exp 0", bus.dataOut); else passes++;
    checks++; if (bus.consumeError !== 1'b0) $display("FAIL mr_rst_err got %0b exp 0", bus.consumeError); else passes++;
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (bus.dataInReady !== 1'b1) $display("FAIL mr_rel_ready got %0b exp 1", bus.dataInReady); else passes++;
    test_single_word(8'h30);
  endtask

  initial begin
    test_reset();
    test_single_word(8'h00);
    test_fill_and_wrap();
    test_partial_last();
    test_over_consume();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
